// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for a single register-file write port with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ready,
  output logic [(1<<ADDR_W)-1:0]    busy_vec,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic [DATA_W-1:0]         rf_write_data
);
  localparam int NREG = 1 << ADDR_W;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gidx;
  logic [PW:0]       sum;
  logic [NUM_REQ-1:0] grant;
  logic              found;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  // Scan from rr_ptr with wraparound; the first valid requester wins and its payload is muxed out
  always_comb begin
    grant = '0;
    gidx = '0;
    found = 1'b0;
    sum = '0;
    g_addr = '0;
    g_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      sum = (sum >= NR) ? sum - NR : sum;
      if (!found && req_valid[sum[PW-1:0]]) begin
        found = 1'b1;
        gidx = sum[PW-1:0];
      end
    end
    grant[gidx] = found;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        g_addr = req_addr[k*ADDR_W +: ADDR_W];
        g_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end
  assign req_ready   = reset_n ? grant : '0;
  assign issue_ready = reset_n && !(busy_q[issue_rd] && issue_rd != '0);
  assign busy_vec      = busy_q;
  assign rf_reg_write  = rf_we_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;
  // Next state: pointer advance past the winner, scoreboard clear-then-allocate (allocate wins), x0 writes suppressed
  always_comb begin
    rr_ptr_d = !found ? rr_ptr_q : (gidx == LAST) ? '0 : gidx + PW'(1);
    busy_d = busy_q;
    if (found) busy_d[g_addr] = 1'b0;
    if (issue_valid && issue_ready) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    rf_we_d   = found && g_addr != '0;
    rf_reg_d  = rf_we_d ? g_addr : rf_reg_q;
    rf_data_d = rf_we_d ? g_data : rf_data_q;
  end
  // All architectural state, cleared asynchronously so reset takes effect without a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [31:0] busy_vec;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  int vectors = 0;
  int ncmp = 0;
  int errs = 0;
  int ptr = 0;
  logic [31:0] mbusy = '0;
  logic        mwe = 1'b0;
  logic [4:0]  mreg = '0;
  logic [31:0] mdata = '0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .busy_vec(busy_vec),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0;
    mbusy = '0;
    mwe = 1'b0;
  endtask

  // One cycle: drive, check combinational outputs, advance the model, check registered outputs after the edge
  task automatic apply(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic iv, input logic [4:0] rd);
    int g;
    logic [2:0] er;
    logic eir;
    logic [4:0] ga;
    req_valid = v;
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
    issue_valid = iv;
    issue_rd = rd;
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) if (g < 0 && v[(ptr + k) % NR]) g = (ptr + k) % NR;
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    eir = !(mbusy[rd] && rd != 0);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("issue_ready", 64'(issue_ready), 64'(eir));
    mwe = 1'b0;
    if (g >= 0) begin
      ptr = (g + 1) % NR;
      ga = req_addr[g*5 +: 5];
      if (ga != 0) begin
        mbusy[ga] = 1'b0;
        mwe = 1'b1;
        mreg = ga;
        mdata = req_data[g*32 +: 32];
      end
    end
    if (iv && eir && rd != 0) mbusy[rd] = 1'b1;
    vectors++;
    @(posedge clk);
    #1;
    chk("busy_vec", 64'(busy_vec), 64'(mbusy));
    chk("rf_reg_write", 64'(rf_reg_write), 64'(mwe));
    if (mwe) begin
      chk("rf_write_reg", 64'(rf_write_reg), 64'(mreg));
      chk("rf_write_data", 64'(rf_write_data), 64'(mdata));
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 3'b111;
    req_addr = '0;
    req_data = '0;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_issue_ready", 64'(issue_ready), 64'(0));
    chk("rst_busy_vec", 64'(busy_vec), 64'(0));
    chk("rst_rf_reg_write", 64'(rf_reg_write), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++)
      apply(3'b111, 5'd4, 5'd5, 5'd6, 32'h1111_0000 + 32'(i), 32'hDEADBEEF, 32'h2222_0000 + 32'(i), 1'b0, 5'd0);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7);
    apply(3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'hCAFE_0007, 1'b1, 5'd7);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7);
    apply(3'b001, 5'd9, 5'd0, 5'd0, 32'h0909_0909, 32'd0, 32'd0, 1'b1, 5'd9);
    apply(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h1234, 32'd0, 1'b0, 5'd0);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd3);
    apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd12);
    req_valid = 3'b100;
    issue_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy_vec", 64'(busy_vec), 64'(0));
    chk("midrst_rf_reg_write", 64'(rf_reg_write), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_issue_ready", 64'(issue_ready), 64'(0));
    reset_n = 1'b1;
    apply(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
    for (int i = 0; i < 300; i++)
      apply(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
